mips_mc_ctrl: RTL and testbench

//  Multicycle MIPS control unit: Moore FSM plus ALU decoder sequencing the shared-memory datapath
//  (regfile, flopenr PC/IR, ALUOut flops, mux2/mux3/mux4 selects, sign/zero extenders).

---
 rtl/mips_mc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore sequencer with a combinational ALU
// decoder, a memory-ready handshake with a bounded wait, and a retire pulse.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
                         BRANCH = 4'd8, IEXEC = 4'd9, IWB = 4'd10, JUMP = 4'd11;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010,
                         OP_J = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  // Counter only needs to reach MEM_TIMEOUT-1; a zero timeout never counts.
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  logic [3:0]    state_reg, state_next;
  logic [CW-1:0] wait_reg, wait_next;
  logic          wait_state, timeout, r_legal;

  assign state = state_reg;

  // Memory-wait bookkeeping shared by FETCH, MEMRD and MEMWR.
  always_comb begin
    wait_state = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    timeout    = (MEM_TIMEOUT > 0) && wait_state && !mem_ready && (wait_reg == WAIT_LAST);
    r_legal    = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                 (funct == 6'b100101) || (funct == 6'b101010);
  end

  // State and wait-counter registers; reset aborts straight to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FETCH;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                      state_next = MEMADR;
          OP_R:                              state_next = r_legal ? EXEC : FETCH;
          OP_BEQ, OP_BNE:                    state_next = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = IEXEC;
          OP_J:                              state_next = JUMP;
          default:                           state_next = FETCH;
        endcase
      end
      MEMADR: state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
      EXEC:   state_next = ALUWB;
      IEXEC:  state_next = IWB;
      default: state_next = FETCH;
    endcase
    if (timeout)
      state_next = FETCH;

    // A timeout in FETCH re-enters FETCH, so it must clear the counter too.
    wait_next = '0;
    if (wait_state && !mem_ready && !timeout && (state_next == state_reg) && (MEM_TIMEOUT > 0))
      wait_next = wait_reg + 1'b1;
  end

  // Per-state datapath controls; strobes are masked while reset is asserted.
  always_comb begin
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    ext_zero    = 1'b0;
    alu_control = ALU_ADD;
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    retire      = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = timeout;
    case (state_reg)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: illegal_op = 1'b0;
          OP_R:    illegal_op = !r_legal;
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = !timeout;
        retire    = mem_ready;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default:   alu_control = ALU_ADD;
        endcase
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = (op == OP_BEQ) ? zero : !zero;
        retire      = 1'b1;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          OP_ANDI: begin alu_control = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin alu_control = ALU_OR;  ext_zero = 1'b1; end
          OP_SLTI: alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      retire     = 1'b0;
      illegal_op = 1'b0;
      mem_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl with a short memory timeout.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       ext_zero, pc_en, retire, illegal_op, mem_err;
  logic [2:0] alu_control;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  mips_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .state(state),
    .retire(retire), .illegal_op(illegal_op), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1; mem_ready = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_retire", retire, 0);
    check("rst_src_b", alu_src_b, 2'b01);
    step(); step();
    reset_n = 1'b1;
    #1;
    check("rel_ir_write", ir_write, 1);
    check("rel_pc_en", pc_en, 1);

    // lw, always ready: 0,1,2,3,4
    op = 6'b100011;
    step(); check("lw_s1", state, 1);
    check("lw_dec_src_b", alu_src_b, 2'b11);
    step(); check("lw_s2", state, 2);
    check("lw_adr_src_b", alu_src_b, 2'b10);
    step(); check("lw_s3", state, 3);
    check("lw_iord", iord, 1);
    check("lw_rd_retire", retire, 0);
    step(); check("lw_s4", state, 4);
    check("lw_reg_write", reg_write, 1);
    check("lw_mem_to_reg", mem_to_reg, 1);
    check("lw_retire", retire, 1);
    step(); check("lw_back", state, 0);
    check("lw_fetch_retire", retire, 0);

    // sw with 3 not-ready cycles in MEMWR
    op = 6'b101011;
    step(); step(); step();
    check("sw_s5", state, 5);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("sw_wait_mem_write", mem_write, 1);
      check("sw_wait_retire", retire, 0);
      check("sw_wait_state", state, 5);
      if (i < 2) step();
    end
    step();
    mem_ready = 1'b1;
    #1;
    check("sw_last_mem_write", mem_write, 1);
    check("sw_last_retire", retire, 1);
    step(); check("sw_back", state, 0);
    check("sw_no_write_fetch", mem_write, 0);

    // beq taken
    op = 6'b000100; zero = 1'b1;
    step(); step();
    check("beq_s8", state, 8);
    check("beq_pc_en", pc_en, 1);
    check("beq_pc_src", pc_src, 2'b01);
    check("beq_alu", alu_control, 3'b110);
    check("beq_retire", retire, 1);
    step(); check("beq_back", state, 0);

    // bne with zero=1 not taken
    op = 6'b000101;
    step(); step();
    check("bne_s8", state, 8);
    check("bne_pc_en", pc_en, 0);
    step(); zero = 1'b0;

    // ori
    op = 6'b001101;
    step(); step();
    check("ori_s9", state, 9);
    check("ori_ext_zero", ext_zero, 1);
    check("ori_alu", alu_control, 3'b001);
    step();
    check("ori_s10", state, 10);
    check("ori_reg_write", reg_write, 1);
    check("ori_reg_dst", reg_dst, 0);
    step();

    // slt R-type
    op = 6'b000000; funct = 6'b101010;
    step(); step();
    check("slt_s6", state, 6);
    check("slt_alu", alu_control, 3'b111);
    step();
    check("slt_s7", state, 7);
    check("slt_reg_dst", reg_dst, 1);
    check("slt_reg_write", reg_write, 1);
    step();

    // illegal funct
    funct = 6'b000111;
    step();
    check("ill_s1", state, 1);
    check("ill_pulse", illegal_op, 1);
    check("ill_reg_write", reg_write, 0);
    step();
    check("ill_back", state, 0);
    check("ill_pulse_gone", illegal_op, 0);

    // jump
    op = 6'b000010;
    step(); step();
    check("j_s11", state, 11);
    check("j_pc_src", pc_src, 2'b10);
    check("j_pc_en", pc_en, 1);
    step();

    // lw timeout in MEMRD
    op = 6'b100011;
    step(); step(); step();
    check("to_s3", state, 3);
    mem_ready = 1'b0;
    #1;
    check("to_w1_err", mem_err, 0);
    step(); check("to_w2_err", mem_err, 0);
    step(); check("to_w3_err", mem_err, 0);
    step(); check("to_w4_err", mem_err, 1);
    check("to_w4_retire", retire, 0);
    check("to_w4_state", state, 3);
    step(); check("to_back", state, 0);
    check("to_fetch_ir_write", ir_write, 0);
    check("to_err_gone", mem_err, 0);
    mem_ready = 1'b1;

    // async reset in EXEC
    op = 6'b000000; funct = 6'b100000;
    #1;
    step(); step();
    check("ex_s6", state, 6);
    reset_n = 1'b0;
    #1;
    check("ex_rst_state", state, 0);
    check("ex_rst_reg_write", reg_write, 0);
    reset_n = 1'b1;
    step();
    check("ex_after_rst", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
